ifc_bus_frontend: RTL and testbench
===================================

IFC_BUS_FRONTEND -- requirements
Module: ifc_bus_frontend

Interface
REQ-001 Parameter: ADDR_W, default 16, width of the latched address and the muxed AD bus.
REQ-002 Parameter: TMO, default 255, DATA-state watchdog limit in clk cycles (1..255).
REQ-003 Port: clk  in  1  system clock, 200 MHz.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: ifc_cs_n  in  1  IFC chip select, active low.
REQ-006 Port: ifc_avd  in  1  IFC address valid, active high.
REQ-007 Port: ifc_we_n / ifc_oe_n  in  1 each  IFC write and read enables, active low.
REQ-008 Port: ifc_ad  in  ADDR_W  muxed address/data bus.
REQ-009 Port: burst_flag  in  1  rw_burst_flag returned by ifc_burst_timer.
REQ-010 Port: start  out  1  one-cycle pulse to ifc_burst_timer en.
REQ-011 Port: rw  out  1  access type, 1=read, 0=write; valid from the start pulse until IDLE.
REQ-012 Port: addr  out  ADDR_W  latched address; wr_data  out  ADDR_W  captured write data.
REQ-013 Port: wr_stb / rd_req / err  out  1 each  single-cycle pulses; busy  out  1  high whenever state is not IDLE.

Function
REQ-014 Control inputs and ifc_ad SHALL be registered before use ("sampled" below); state machine states: IDLE, ADDR, DATA, HOLD.
REQ-015 IDLE: sampled cs_n=0 and avd=1 SHALL go to ADDR and latch addr from sampled ad in the same edge.
REQ-016 ADDR: sampled avd=0 with we_n=0 SHALL go to DATA with rw=0; with oe_n=0, DATA with rw=1; otherwise stay.
REQ-017 start SHALL pulse high exactly one cycle, coincident with the first DATA cycle; rd_req SHALL pulse on that same cycle when rw=1.
REQ-018 Write: on the first cycle burst_flag is sampled 1 in DATA, wr_data SHALL capture sampled ad and wr_stb SHALL pulse once; later burst_flag highs in the same access SHALL NOT re-strobe.
REQ-019 DATA: sampled cs_n=1 SHALL go to HOLD; HOLD SHALL go to IDLE after one cycle.
REQ-020 ADDR: sampled cs_n=1 SHALL return to IDLE directly with no start, rd_req or wr_stb.
REQ-021 Sampled we_n=0 and oe_n=0 together in ADDR or DATA SHALL pulse err once and go to HOLD; error takes priority over normal transitions.
REQ-022 Watchdog: 8-bit counter cleared on entry to DATA, increments each DATA cycle; reaching TMO SHALL pulse err and go to HOLD.
REQ-023 avd re-asserted during DATA SHALL be ignored; a new access needs a return to IDLE.
REQ-024 addr, wr_data and rw SHALL hold their values in IDLE until the next latch.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE and all outputs, sample registers and the watchdog to 0, including mid-access.
REQ-026 After rst_n release the first access is accepted when sampled cs_n=0, avd=1.

Configuration
REQ-027 Macro IFC_FRONTEND_SYNC_EN defined: control inputs (cs_n, avd, we_n, oe_n) pass a 2-flop synchronizer before the sample register, giving 3-cycle input latency; ad keeps a matching 3-stage delay.
REQ-028 Macro IFC_FRONTEND_SYNC_EN undefined: single sample register only, 1-cycle input latency; all other behaviour identical.

Structure
REQ-029 Shared package ifc_pkg SHALL hold the state encoding (IDLE=0, ADDR=1, DATA=2, HOLD=3) and the ADDR_W/TMO defaults.
REQ-030 The synchronizer SHALL be sub-module ifc_sync2 (width-parameterised, async active-low reset); no other sub-modules.

Verification
REQ-031 Read: cs_n=0, avd=1, ad=0x1234 for 2 cycles, then avd=0, oe_n=0 -> addr=0x1234, rw=1, start and rd_req pulse once together, busy=1.
REQ-032 Write: address 0x00A0, we_n=0, ad=0xBEEF, burst_flag high 3 cycles -> wr_data=0xBEEF, wr_stb exactly one pulse, on the first flag cycle.
REQ-033 Abort: cs_n rises while in ADDR -> IDLE, no start/err pulse, busy drops.
REQ-034 Conflict: we_n=0 and oe_n=0 together in DATA -> one err pulse, HOLD, then IDLE once cs_n=1.
REQ-035 Timeout: TMO=10, hold cs_n=0 in DATA -> err pulses 10 cycles after start, HOLD then IDLE.
REQ-036 Reset mid-write: rst_n low during DATA -> all outputs 0 immediately; the next access after release behaves as REQ-031.

Source files
------------

// File: rtl/ifc_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the IFC bus front end: state encoding, default
// sizing and the watchdog counter width.
package ifc_pkg;

  localparam int unsigned IFC_ADDR_W_DEF = 16;
  localparam int unsigned IFC_TMO_DEF    = 255;
  localparam int unsigned IFC_WDOG_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } ifc_state_e;

endpackage

// File: rtl/ifc_sync2.sv
`timescale 1ns/1ps
// Two-flop synchronizer, width-parameterised, async active-low reset.
module ifc_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability chain: first flop may go metastable, second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/ifc_bus_frontend.sv
`timescale 1ns/1ps
// IFC bus front end: samples the muxed IFC address/data bus, latches the
// address, qualifies read/write accesses and launches the burst timer.
// Build option: define IFC_FRONTEND_SYNC_EN to put a 2-flop synchronizer in
// front of the control sample register (3-cycle input latency, ad delayed to
// match); undefined gives a single sample register (1-cycle latency).
//
// state | meaning
// IDLE  | waiting for cs_n=0 with avd=1
// ADDR  | address latched, waiting for avd=0 with we_n or oe_n low
// DATA  | access active, watchdog running, write strobe armed
// HOLD  | one-cycle turnaround back to IDLE
module ifc_bus_frontend
  import ifc_pkg::*;
#(
  parameter int unsigned ADDR_W = IFC_ADDR_W_DEF,
  parameter int unsigned TMO    = IFC_TMO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifc_cs_n,
  input  logic              ifc_avd,
  input  logic              ifc_we_n,
  input  logic              ifc_oe_n,
  input  logic [ADDR_W-1:0] ifc_ad,
  input  logic              burst_flag,
  output logic              start,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] wr_data,
  output logic              wr_stb,
  output logic              rd_req,
  output logic              err,
  output logic              busy
);

  localparam logic [IFC_WDOG_W-1:0] TMO_LIM = IFC_WDOG_W'(TMO);

  logic [3:0]        w_ctl_in;
  logic [3:0]        w_ctl_pre;
  logic [ADDR_W-1:0] w_ad_pre;
  logic [3:0]        r_ctl;
  logic [ADDR_W-1:0] r_ad;

  assign w_ctl_in = {ifc_cs_n, ifc_avd, ifc_we_n, ifc_oe_n};

`ifdef IFC_FRONTEND_SYNC_EN
  logic [ADDR_W-1:0] r_ad_d1;
  logic [ADDR_W-1:0] r_ad_d2;

  ifc_sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (w_ctl_in),
    .q     (w_ctl_pre)
  );

  // Delay ad by two stages so it stays aligned with the synchronized controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ad_d1 <= '0;
      r_ad_d2 <= '0;
    end else begin
      r_ad_d1 <= ifc_ad;
      r_ad_d2 <= r_ad_d1;
    end
  end

  assign w_ad_pre = r_ad_d2;
`else
  assign w_ctl_pre = w_ctl_in;
  assign w_ad_pre  = ifc_ad;
`endif

  // Sample register: the FSM only ever looks at these registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl <= '0;
      r_ad  <= '0;
    end else begin
      r_ctl <= w_ctl_pre;
      r_ad  <= w_ad_pre;
    end
  end

  logic w_cs_n, w_avd, w_we_n, w_oe_n, w_conflict;

  assign w_cs_n     = r_ctl[3];
  assign w_avd      = r_ctl[2];
  assign w_we_n     = r_ctl[1];
  assign w_oe_n     = r_ctl[0];
  assign w_conflict = !w_we_n && !w_oe_n;

  ifc_state_e              r_state, w_state_nxt;
  logic                    r_start, r_rd_req, r_wr_stb, r_err, r_rw, r_wr_done;
  logic [ADDR_W-1:0]       r_addr, r_wr_data;
  logic [IFC_WDOG_W-1:0]   r_wdog, w_wdog_inc;
  logic                    w_start_nxt, w_rd_req_nxt, w_wr_stb_nxt, w_err_nxt;
  logic                    w_rw_nxt, w_wr_done_nxt;
  logic [ADDR_W-1:0]       w_addr_nxt, w_wr_data_nxt;
  logic [IFC_WDOG_W-1:0]   w_wdog_nxt;

  assign w_wdog_inc = r_wdog + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next register values; pulses default low every cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_nxt   = 1'b0;
    w_rd_req_nxt  = 1'b0;
    w_wr_stb_nxt  = 1'b0;
    w_err_nxt     = 1'b0;
    w_rw_nxt      = r_rw;
    w_addr_nxt    = r_addr;
    w_wr_data_nxt = r_wr_data;
    w_wdog_nxt    = r_wdog;
    w_wr_done_nxt = r_wr_done;
    case (r_state)
      ST_IDLE: begin
        if (!w_cs_n && w_avd) begin
          w_state_nxt = ST_ADDR;
          w_addr_nxt  = r_ad;
        end
      end
      ST_ADDR: begin
        if (w_conflict) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (w_cs_n) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_avd && !w_we_n) begin
          w_state_nxt   = ST_DATA;
          w_rw_nxt      = 1'b0;
          w_start_nxt   = 1'b1;
          w_wdog_nxt    = '0;
          w_wr_done_nxt = 1'b0;
        end else if (!w_avd && !w_oe_n) begin
          w_state_nxt   = ST_DATA;
          w_rw_nxt      = 1'b1;
          w_start_nxt   = 1'b1;
          w_rd_req_nxt  = 1'b1;
          w_wdog_nxt    = '0;
          w_wr_done_nxt = 1'b0;
        end
      end
      ST_DATA: begin
        w_wdog_nxt = w_wdog_inc;
        if (w_conflict) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (w_cs_n) begin
          w_state_nxt = ST_HOLD;
        end else if (w_wdog_inc == TMO_LIM) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
        // Only the first burst_flag of a write access strobes the data out.
        if (!w_conflict && !r_rw && burst_flag && !r_wr_done) begin
          w_wr_data_nxt = r_ad;
          w_wr_stb_nxt  = 1'b1;
          w_wr_done_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output, latch and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start   <= 1'b0;
      r_rd_req  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_err     <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wdog    <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_start   <= w_start_nxt;
      r_rd_req  <= w_rd_req_nxt;
      r_wr_stb  <= w_wr_stb_nxt;
      r_err     <= w_err_nxt;
      r_rw      <= w_rw_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_wdog    <= w_wdog_nxt;
      r_wr_done <= w_wr_done_nxt;
    end
  end

  assign start   = r_start;
  assign rd_req  = r_rd_req;
  assign wr_stb  = r_wr_stb;
  assign err     = r_err;
  assign rw      = r_rw;
  assign addr    = r_addr;
  assign wr_data = r_wr_data;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ifc_bus_frontend.sv
`timescale 1ns/1ps
// Scoreboard bench for ifc_bus_frontend: each access pushes the output
// events it must produce; a negedge monitor pops and compares them.
module tb_ifc_bus_frontend;

  localparam int AW    = 16;
  localparam int TMO_T = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifc_cs_n, ifc_avd, ifc_we_n, ifc_oe_n, burst_flag;
  logic [AW-1:0] ifc_ad;
  logic          start, rw, wr_stb, rd_req, err, busy;
  logic [AW-1:0] addr, wr_data;

  ifc_bus_frontend #(.ADDR_W(AW), .TMO(TMO_T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ifc_cs_n   (ifc_cs_n),
    .ifc_avd    (ifc_avd),
    .ifc_we_n   (ifc_we_n),
    .ifc_oe_n   (ifc_oe_n),
    .ifc_ad     (ifc_ad),
    .burst_flag (burst_flag),
    .start      (start),
    .rw         (rw),
    .addr       (addr),
    .wr_data    (wr_data),
    .wr_stb     (wr_stb),
    .rd_req     (rd_req),
    .err        (err),
    .busy       (busy)
  );

  always #2.5 clk = ~clk;

  // flg = {start, rd_req, wr_stb, err}; dly < 0 means timing not checked
  typedef struct {
    logic [3:0]    flg;
    logic [AW-1:0] a;
    logic          r;
    logic [AW-1:0] d;
    int            dly;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc_since = 0;
  logic [3:0] mon_f;
  ev_t        mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, got no response expected one", nm);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    mon_f = {start, rd_req, wr_stb, err};
    cyc_since++;
    if (rst_n === 1'b1 && mon_f != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {28'd0, mon_f}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_flags", {28'd0, mon_f}, {28'd0, mon_e.flg});
        chk("event_addr", addr, mon_e.a);
        if (mon_e.flg[3]) chk("event_rw", rw, mon_e.r);
        if (mon_e.flg[1]) chk("event_wr_data", wr_data, mon_e.d);
        if (mon_e.dly >= 0) chk("event_delay", cyc_since, mon_e.dly);
      end
      cyc_since = 0;
    end
  end

  task automatic push(input logic [3:0] f, input logic [AW-1:0] a, input logic r,
                      input logic [AW-1:0] d, input int dly);
    ev_t e;
    e.flg = f; e.a = a; e.r = r; e.d = d; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    ifc_cs_n = 1'b1; ifc_avd = 1'b0; ifc_we_n = 1'b1; ifc_oe_n = 1'b1; burst_flag = 1'b0;
  endtask

  task automatic addr_phase(input logic [AW-1:0] a, input int n);
    @(negedge clk);
    ifc_cs_n = 1'b0; ifc_avd = 1'b1; ifc_ad = a;
    cyc(n);
  endtask

  task automatic wait_start(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) fail_to(nm);
  endtask

  task automatic wait_err(input string nm, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) fail_to(nm);
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_to(nm);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input bit avd_poke);
    bit ok;
    push(4'b1100, a, 1'b1, '0, -1);
    addr_phase(a, 2);
    ifc_avd = 1'b0; ifc_oe_n = 1'b0; ifc_ad = AW'($urandom);
    wait_start("read_start", ok);
    if (ok) begin
      chk("read_busy", busy, 1);
      if (avd_poke) begin
        ifc_avd = 1'b1; ifc_ad = ~a;
        cyc(1);
        ifc_avd = 1'b0;
      end
      cyc(hold);
    end
    bus_idle();
    wait_idle("read_idle");
    chk("read_addr_held", addr, a);
    chk("read_rw_held", rw, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] d,
                          input int gap, input int nflag);
    bit ok;
    push(4'b1000, a, 1'b0, '0, -1);
    push(4'b0010, a, 1'b0, d, gap + 1);
    addr_phase(a, 2);
    ifc_avd = 1'b0; ifc_we_n = 1'b0; ifc_ad = d;
    wait_start("write_start", ok);
    if (ok) begin
      chk("write_busy", busy, 1);
      cyc(gap);
      burst_flag = 1'b1;
      cyc(nflag);
      burst_flag = 1'b0;
    end
    bus_idle();
    wait_idle("write_idle");
    chk("write_data_held", wr_data, d);
    chk("write_addr_held", addr, a);
    chk("write_rw_held", rw, 0);
  endtask

  task automatic do_abort(input logic [AW-1:0] a);
    addr_phase(a, 2);
    chk("abort_busy_in_addr", busy, 1);
    ifc_cs_n = 1'b1; ifc_avd = 1'b0;
    wait_idle("abort_idle");
    chk("abort_addr", addr, a);
    cyc(2);
    chk("abort_busy_low", busy, 0);
  endtask

  task automatic do_conflict_data(input logic [AW-1:0] a, input int c);
    bit ok;
    push(4'b1000, a, 1'b0, '0, -1);
    push(4'b0001, a, 1'b0, '0, c + 2);
    addr_phase(a, 1);
    ifc_avd = 1'b0; ifc_we_n = 1'b0; ifc_ad = AW'($urandom);
    wait_start("conflict_start", ok);
    if (ok) begin
      cyc(c);
      ifc_oe_n = 1'b0;
      wait_err("conflict_err", 10);
      chk("conflict_busy_hold", busy, 1);
      cyc(1);
      chk("conflict_idle_after_hold", busy, 0);
    end
    bus_idle();
    wait_idle("conflict_idle");
  endtask

  task automatic do_conflict_addr(input logic [AW-1:0] a);
    push(4'b0001, a, 1'b0, '0, -1);
    addr_phase(a, 2);
    ifc_avd = 1'b0; ifc_we_n = 1'b0; ifc_oe_n = 1'b0;
    wait_err("addr_conflict_err", 10);
    bus_idle();
    wait_idle("addr_conflict_idle");
  endtask

  task automatic do_timeout(input logic [AW-1:0] a);
    bit ok;
    push(4'b1100, a, 1'b1, '0, -1);
    push(4'b0001, a, 1'b1, '0, TMO_T);
    addr_phase(a, 2);
    ifc_avd = 1'b0; ifc_oe_n = 1'b0;
    wait_start("timeout_start", ok);
    if (ok) begin
      wait_err("timeout_err", TMO_T + 5);
      chk("timeout_busy_hold", busy, 1);
      cyc(1);
      chk("timeout_idle_after_hold", busy, 0);
    end
    bus_idle();
    wait_idle("timeout_idle");
  endtask

  task automatic do_reset_mid_write(input logic [AW-1:0] a, input logic [AW-1:0] d);
    bit ok;
    push(4'b1000, a, 1'b0, '0, -1);
    addr_phase(a, 2);
    ifc_avd = 1'b0; ifc_we_n = 1'b0; ifc_ad = d;
    wait_start("rstmid_start", ok);
    cyc(1);
    #1.3 rst_n = 1'b0;
    #0.5;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_addr", addr, 0);
    chk("rstmid_wr_data", wr_data, 0);
    chk("rstmid_rw", rw, 0);
    chk("rstmid_pulses", {start, rd_req, wr_stb, err}, 0);
    exp_q.delete();
    bus_idle();
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    bus_idle();
    ifc_ad = '0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rw", rw, 0);
    chk("rst_pulses", {start, rd_req, wr_stb, err}, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    do_read(16'h1234, 2, 1'b0);
    do_write(16'h00A0, 16'hBEEF, 0, 3);
    do_abort(16'h5A5A);
    do_conflict_data(AW'($urandom), 1);
    do_conflict_addr(AW'($urandom));
    do_timeout(AW'($urandom));
    do_reset_mid_write(16'hC0DE, 16'h7777);
    do_read(16'h1234, 2, 1'b0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: do_read(AW'($urandom), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        1: do_write(AW'($urandom), AW'($urandom), $urandom_range(0, 2), $urandom_range(1, 3));
        2: do_abort(AW'($urandom));
        3: do_conflict_data(AW'($urandom), $urandom_range(0, 3));
        4: do_conflict_addr(AW'($urandom));
        default: do_timeout(AW'($urandom));
      endcase
      cyc($urandom_range(0, 2));
    end

    cyc(5);
    chk("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
